cdc_event_pacer: RTL and testbench

Event pacer that sits directly upstream of the toggle-based CDC synchronizer in the clk_a domain. It accepts bursty single-cycle event strobes, buffers them in a saturating pending counter, and meters them into the synchronizer as single-cycle valid pulses, issuing each pulse only after the previous one has been acknowledged. Events are never lost silently: every event is either delivered or counted as an overflow.

---
 rtl/cdc_pkg.sv | 19 +
 rtl/sat_updown_cnt.sv | 48 ++++
 rtl/cdc_event_pacer.sv | 131 +++++++++++++
 tb/tb_cdc_event_pacer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
// Shared types and default constants for the clk_a-side CDC event pacer.
//   pacer_state_t     : pacer FSM state (IDLE, SEND, WAIT)
//   PACER_CNT_W_DEF   : default pending-counter width
//   PACER_TIMEOUT_DEF : default acknowledge timeout in clk_a cycles
// -----------------------------------------------------------------------------
package cdc_pkg;

    localparam int unsigned PACER_CNT_W_DEF   = 8;
    localparam int unsigned PACER_TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } pacer_state_t;

endpackage

// File: rtl/sat_updown_cnt.sv
// -----------------------------------------------------------------------------
// sat_updown_cnt
// Saturating up/down counter. An increment request at full scale is refused
// unless a decrement happens in the same cycle; a refused request is flagged
// on drop_c. A decrement at zero is ignored.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset (count -> 0)
//   inc    : increment request
//   dec    : decrement request
//   count  : registered count value
//   sat_c  : count is at full scale (2^W - 1)
//   drop_c : increment request refused this cycle
// -----------------------------------------------------------------------------
module sat_updown_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat_c,
    output logic         drop_c
);

    localparam logic [W-1:0] MAX_CNT = {W{1'b1}};

    logic dec_ok;
    logic inc_ok;

    assign sat_c  = (count == MAX_CNT);
    assign dec_ok = dec && (count != '0);
    // A same-cycle decrement frees a slot, so the event is still accepted.
    assign drop_c = inc && sat_c && !dec_ok;
    assign inc_ok = inc && !drop_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc_ok && !dec_ok) begin
            count <= count + W'(1);
        end else if (dec_ok && !inc_ok) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/cdc_event_pacer.sv
// -----------------------------------------------------------------------------
// cdc_event_pacer
// Buffers bursty single-cycle event strobes in a saturating pending counter and
// meters them into a toggle-based CDC synchronizer as single-cycle valid
// pulses, one per acknowledge round trip. Dropped events set a sticky flag.
// Optional feature macro: PACER_TIMEOUT_EN adds an acknowledge timeout
// (parameter TIMEOUT_CYC, sticky a_timeout_out, forced WAIT -> IDLE).
// Ports:
//   clk_a         : clock, rising edge
//   a_reset_in    : synchronous active-high reset
//   a_ev_in       : event strobe, one event per high cycle
//   a_rdy_in      : synchronizer ready level (1 = idle)
//   a_ovf_clr_in  : clears a_ovf_out (a same-cycle new overflow wins)
//   a_vld_out     : registered single-cycle valid pulse to the synchronizer
//   a_pending_out : buffered event count
//   a_busy_out    : FSM not idle or events pending
//   a_ovf_out     : sticky overflow flag
//   a_timeout_out : sticky acknowledge-timeout flag (PACER_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module cdc_event_pacer
    import cdc_pkg::*;
#(
    parameter int unsigned CNT_W       = PACER_CNT_W_DEF
`ifdef PACER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = PACER_TIMEOUT_DEF
`endif
) (
    input  logic             clk_a,
    input  logic             a_reset_in,
    input  logic             a_ev_in,
    input  logic             a_rdy_in,
    input  logic             a_ovf_clr_in,
    output logic             a_vld_out,
    output logic [CNT_W-1:0] a_pending_out,
    output logic             a_busy_out,
    output logic             a_ovf_out
`ifdef PACER_TIMEOUT_EN
    ,
    output logic             a_timeout_out
`endif
);

`ifdef PACER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    pacer_state_t state;
    logic         issue_c;
    logic         pend_sat;
    logic         pend_drop;
    logic         unused_sat;

    // Issue only from IDLE with something buffered and the synchronizer idle.
    assign issue_c = (state == IDLE) && (a_pending_out != '0) && a_rdy_in;

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_pending (
        .clk    (clk_a),
        .reset  (a_reset_in),
        .inc    (a_ev_in),
        .dec    (issue_c),
        .count  (a_pending_out),
        .sat_c  (pend_sat),
        .drop_c (pend_drop)
    );

    assign unused_sat = pend_sat;

    assign a_busy_out = (state != IDLE) || (a_pending_out != '0);

    // Handshake FSM; a_vld_out is high exactly in SEND.
    always_ff @(posedge clk_a) begin
        if (a_reset_in) begin
            state     <= IDLE;
            a_vld_out <= 1'b0;
`ifdef PACER_TIMEOUT_EN
            wait_cnt      <= '0;
            a_timeout_out <= 1'b0;
`endif
        end else begin
            a_vld_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_c) begin
                        state     <= SEND;
                        a_vld_out <= 1'b1;
                    end
                end
                SEND: begin
                    // a_rdy_in is not sampled here; it drops only after the pulse.
                    state <= WAIT;
`ifdef PACER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
`ifdef PACER_TIMEOUT_EN
                    if (a_rdy_in) begin
                        state <= IDLE;
                    end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        a_timeout_out <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`else
                    if (a_rdy_in) begin
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow; a new drop takes priority over clear.
    always_ff @(posedge clk_a) begin
        if (a_reset_in) begin
            a_ovf_out <= 1'b0;
        end else if (pend_drop) begin
            a_ovf_out <= 1'b1;
        end else if (a_ovf_clr_in) begin
            a_ovf_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_event_pacer.sv
// -----------------------------------------------------------------------------
// tb_cdc_event_pacer
// Self-checking bench for cdc_event_pacer: directed scenarios followed by
// randomized event/acknowledge traffic, all compared against a behavioural
// model of the pacing rules. Includes a synchronizer acknowledge emulator.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdc_event_pacer;

    localparam int unsigned CW   = 3;
    localparam int          MAXP = (1 << CW) - 1;

    logic          clk_a = 1'b0;
    logic          a_reset_in;
    logic          a_ev_in;
    logic          a_rdy_in;
    logic          a_ovf_clr_in;
    logic          a_vld_out;
    logic [CW-1:0] a_pending_out;
    logic          a_busy_out;
    logic          a_ovf_out;
`ifdef PACER_TIMEOUT_EN
    logic          a_timeout_out;
`endif

    always #5 clk_a = ~clk_a;

    cdc_event_pacer #(
        .CNT_W (CW)
    ) dut (
        .clk_a         (clk_a),
        .a_reset_in    (a_reset_in),
        .a_ev_in       (a_ev_in),
        .a_rdy_in      (a_rdy_in),
        .a_ovf_clr_in  (a_ovf_clr_in),
        .a_vld_out     (a_vld_out),
        .a_pending_out (a_pending_out),
        .a_busy_out    (a_busy_out),
        .a_ovf_out     (a_ovf_out)
`ifdef PACER_TIMEOUT_EN
        ,
        .a_timeout_out (a_timeout_out)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: events owed, whether a pulse is outstanding, and how
    // many edges have passed since that pulse was issued.
    int m_pend  = 0;
    bit m_out   = 1'b0;
    int m_since = 0;
    bit m_ovf   = 1'b0;
    bit m_vld   = 1'b0;

    // Synchronizer emulation: ready stays low for ack_left more cycles.
    int ack_left   = 0;
    int ack_fixed  = 0;
    int ack_max    = 4;
    int glitch_pct = 0;

    int pulses = 0;
    int peak   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model at posedge, compare.
    task automatic step(input bit ev, input bit clr, input bit rst);
        bit rdy;
        bit issue;
        bit acc;
        @(negedge clk_a);
        if (m_vld) begin
            ack_left = (ack_fixed > 0) ? ack_fixed : int'($urandom_range(ack_max, 2));
        end else if (ack_left > 0) begin
            ack_left--;
        end
        rdy = (ack_left == 0) && (int'($urandom_range(99, 0)) >= glitch_pct);
        a_ev_in      = ev;
        a_ovf_clr_in = clr;
        a_reset_in   = rst;
        a_rdy_in     = rdy;
        @(posedge clk_a);
        if (rst) begin
            m_pend   = 0;
            m_out    = 1'b0;
            m_since  = 0;
            m_ovf    = 1'b0;
            ack_left = 0;
        end else begin
            issue = !m_out && (m_pend > 0) && rdy;
            acc   = ev && ((m_pend < MAXP) || issue);
            if (m_out) begin
                m_since++;
                if (m_since >= 2 && rdy) m_out = 1'b0;
            end
            if (issue) begin
                m_out   = 1'b1;
                m_since = 0;
            end
            m_pend = m_pend + int'(acc) - int'(issue);
            if (ev && !acc) m_ovf = 1'b1;
            else if (clr)   m_ovf = 1'b0;
        end
        m_vld = m_out && (m_since == 0);
        #1;
        chk("vld",     int'(a_vld_out),     int'(m_vld));
        chk("pending", int'(a_pending_out), m_pend);
        chk("busy",    int'(a_busy_out),    int'(m_out || (m_pend != 0)));
        chk("ovf",     int'(a_ovf_out),     int'(m_ovf));
`ifdef PACER_TIMEOUT_EN
        chk("timeout", int'(a_timeout_out), 0);
`endif
        if (a_vld_out) pulses++;
        if (int'(a_pending_out) > peak) peak = int'(a_pending_out);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset_in   = 1'b1;
        a_ev_in      = 1'b0;
        a_rdy_in     = 1'b1;
        a_ovf_clr_in = 1'b0;

        // Reset values
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_vld",  int'(a_vld_out),     0);
        chk("rst_pend", int'(a_pending_out), 0);
        chk("rst_busy", int'(a_busy_out),    0);
        chk("rst_ovf",  int'(a_ovf_out),     0);

        // Single event: pending 1 then pulse two edges after the strobe
        step(1, 0, 0);
        chk("lat_pend1", int'(a_pending_out), 1);
        chk("lat_vld0",  int'(a_vld_out),     0);
        step(0, 0, 0);
        chk("lat_vld1",  int'(a_vld_out),     1);
        chk("lat_pend0", int'(a_pending_out), 0);
        step(0, 0, 0);
        chk("lat_vld_one_cycle", int'(a_vld_out), 0);
        repeat (10) step(0, 0, 0);

        // Five back-to-back events, 6-cycle acknowledge round trip
        ack_fixed = 6;
        pulses    = 0;
        peak      = 0;
        repeat (5) step(1, 0, 0);
        repeat (40) step(0, 0, 0);
        chk("burst_pulses", pulses, 5);
        chk("burst_peak",   peak,   4);
        chk("burst_idle",   int'(a_busy_out), 0);

        // Saturation under a stalled handshake; set beats clear
        step(0, 0, 1);
        ack_fixed = 60;
        repeat (12) step(1, 0, 0);
        chk("sat_pend", int'(a_pending_out), MAXP);
        chk("sat_ovf",  int'(a_ovf_out),     1);
        step(1, 1, 0);
        chk("ovf_set_wins", int'(a_ovf_out),     1);
        chk("sat_hold",     int'(a_pending_out), MAXP);
        step(0, 1, 0);
        chk("ovf_clear", int'(a_ovf_out), 0);

        // Event on the same edge as IDLE -> SEND with pending = 1
        step(0, 0, 1);
        ack_fixed = 0;
        ack_max   = 3;
        step(1, 0, 0);
        step(1, 0, 0);
        chk("same_edge_pend", int'(a_pending_out), 1);
        chk("same_edge_vld",  int'(a_vld_out),     1);
        pulses = 0;
        repeat (12) step(0, 0, 0);
        chk("same_edge_second", pulses, 1);

        // Reset while waiting for the acknowledge with three events buffered
        step(0, 0, 1);
        ack_fixed = 60;
        repeat (4) step(1, 0, 0);
        chk("wait_pend3", int'(a_pending_out), 3);
        chk("wait_busy",  int'(a_busy_out),    1);
        step(0, 0, 1);
        chk("mid_rst_vld",  int'(a_vld_out),     0);
        chk("mid_rst_pend", int'(a_pending_out), 0);
        chk("mid_rst_busy", int'(a_busy_out),    0);
        ack_fixed = 0;
        pulses    = 0;
        repeat (8) step(0, 0, 0);
        chk("post_rst_no_pulse", pulses, 0);

        // Randomized traffic across load/latency mixes
        for (int ph = 0; ph < 6; ph++) begin
            int ev_pct;
            ev_pct     = 10 + 15 * ph;
            ack_max    = 2 + 6 * (ph % 3);
            glitch_pct = (ph % 2 == 1) ? 15 : 0;
            repeat (600) begin
                step(int'($urandom_range(99, 0)) < ev_pct,
                     int'($urandom_range(99, 0)) < 3,
                     int'($urandom_range(999, 0)) < 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
